// File: rtl/fp_posit_norm_pack_pkg.sv
// Shared definitions for the FP16 normalise/round/pack stage that sits
// behind the FP16 x posit(4,0) bit-serial multiplier.
//   FP16_BIAS  : IEEE half-precision exponent bias
//   FP16_NAN   : canonical quiet NaN emitted for a NaR weight
//   FP16_PINF  : +infinity; the sign bit is OR-ed in for -infinity
//   state_t    : controller states, 2-bit encoding
//   norm_act_t : the single action chosen in a NORM cycle
//   flags_t    : {nan, overflow, underflow} status reported with a result
package fp_posit_norm_pack_pkg;

  localparam int          FP16_BIAS = 15;
  localparam logic [15:0] FP16_NAN  = 16'h7E00;
  localparam logic [15:0] FP16_PINF = 16'h7C00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    ACT_NAR    = 3'd0,
    ACT_ZERO   = 3'd1,
    ACT_RSHIFT = 3'd2,
    ACT_UFLOW  = 3'd3,
    ACT_LSHIFT = 3'd4,
    ACT_DONE   = 3'd5
  } norm_act_t;

  typedef struct packed {
    logic nan;
    logic overflow;
    logic underflow;
  } flags_t;

endpackage

// File: rtl/fp_posit_norm_pack_fp16_rne_round.sv
// fp16_rne_round: combinational round-to-nearest-even and pack.
// Takes a normalised mantissa (hidden one at bit MAN_WIDTH), the guard and
// sticky bits collected by the right shifts, and the signed biased exponent.
// Ports:
//   sign      in  result sign
//   e         in  signed biased exponent (EXP_WIDTH+2 bits, headroom for carries)
//   mant      in  normalised mantissa incl. hidden one
//   guard     in  first bit below the kept LSB
//   sticky    in  OR of every bit below guard
//   fp        out packed word {sign, exp, frac}
//   overflow  out exponent saturated; fp is signed infinity
//   underflow out exponent below the normal range; fp is signed zero
module fp16_rne_round
  import fp_posit_norm_pack_pkg::*;
#(
  parameter int EXP_WIDTH = 5,
  parameter int MAN_WIDTH = 10
) (
  input  logic                          sign,
  input  logic signed [EXP_WIDTH+1:0]   e,
  input  logic [MAN_WIDTH:0]            mant,
  input  logic                          guard,
  input  logic                          sticky,
  output logic [EXP_WIDTH+MAN_WIDTH:0]  fp,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int E_W  = EXP_WIDTH + 2;
  localparam int FP_W = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam logic signed [E_W-1:0] E_ONE = E_W'(1);
  localparam logic signed [E_W-1:0] E_MAX = E_W'((1 << EXP_WIDTH) - 1);

  logic                  round_up;
  logic [MAN_WIDTH+1:0]  sum;
  logic                  carry;
  logic signed [E_W-1:0] e_adj;
  logic [MAN_WIDTH-1:0]  frac;

  always_comb begin
    round_up  = 1'b0;
    sum       = '0;
    carry     = 1'b0;
    e_adj     = e;
    frac      = '0;
    fp        = '0;
    overflow  = 1'b0;
    underflow = 1'b0;

    // Ties go to the even mantissa: an exact half only rounds up when the
    // kept LSB is already odd.
    round_up = guard & (sticky | mant[0]);
    sum      = {1'b0, mant} + {{(MAN_WIDTH+1){1'b0}}, round_up};
    // A carry out of the hidden bit leaves 10.000..0; renormalise by one.
    carry    = sum[MAN_WIDTH+1];
    e_adj    = carry ? (e + E_ONE) : e;
    frac     = carry ? sum[MAN_WIDTH:1] : sum[MAN_WIDTH-1:0];

    if (e_adj >= E_MAX) begin
      overflow = 1'b1;
      fp       = {sign, FP16_PINF[FP_W-2:0]};
    end else if (e_adj < E_ONE) begin
      // Only reachable when the incoming exponent was already 0 with the
      // hidden bit in place; subnormals are never emitted.
      underflow = 1'b1;
      fp        = {sign, {(FP_W-1){1'b0}}};
    end else begin
      fp = {sign, e_adj[EXP_WIDTH-1:0], frac};
    end
  end

endmodule

// File: rtl/fp_posit_norm_pack.sv
// fp_posit_norm_pack: captures the unnormalised product of the FP16 x
// posit(4,0) multiplier, normalises it one shift per cycle, rounds RNE to
// MAN_WIDTH fraction bits and presents a packed FP16 word.
// Ports:
//   clk, rst (async, active-low)
//   in_done/in_sign/in_exp/in_mant/in_zero/in_nar : product fields, valid on in_done
//   in_ready    : high only in IDLE; a pulse seen while low is dropped
//   out_valid/out_ready/out_fp/out_flags          : result handshake
//   overrun/clr_overrun                           : sticky dropped-input flag
//
// Handshake: out_valid rises with a result and stays high, with out_fp and
// out_flags frozen, until a cycle in which out_ready is also high; that
// edge transfers the word and the block returns to IDLE (in_ready=1 on the
// following cycle). out_valid never drops without a transfer except on reset.
module fp_posit_norm_pack
  import fp_posit_norm_pack_pkg::*;
#(
  parameter int EXP_WIDTH  = 5,
  parameter int MAN_WIDTH  = 10,
  parameter int PROD_WIDTH = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_done,
  input  logic                          in_sign,
  input  logic [EXP_WIDTH-1:0]          in_exp,
  input  logic [PROD_WIDTH-1:0]         in_mant,
  input  logic                          in_zero,
  input  logic                          in_nar,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0]  out_fp,
  output logic [2:0]                    out_flags,
  output logic                          overrun,
  input  logic                          clr_overrun
);

  localparam int E_W  = EXP_WIDTH + 2;
  localparam int FP_W = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam logic signed [E_W-1:0] E_ONE = E_W'(1);

  state_t                 state_q, state_d;
  norm_act_t              act;
  logic                   sign_q, zero_q, nar_q, guard_q, sticky_q;
  logic signed [E_W-1:0]  e_q;
  logic [PROD_WIDTH-1:0]  mant_q;
  flags_t                 flags_q;
  logic [FP_W-1:0]        rnd_fp;
  logic                   rnd_ovf, rnd_unf;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // One normalisation action per cycle, in priority order. Left shifts stop
  // before the exponent would reach 0 so that no subnormal is produced.
  always_comb begin
    act = ACT_DONE;
    if (nar_q)                                          act = ACT_NAR;
    else if (zero_q || mant_q == '0)                    act = ACT_ZERO;
    else if (mant_q[PROD_WIDTH-1:MAN_WIDTH+1] != '0)    act = ACT_RSHIFT;
    else if (!mant_q[MAN_WIDTH])                        act = (e_q <= E_ONE) ? ACT_UFLOW : ACT_LSHIFT;
  end

  // ---------------- next-state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_done) state_d = ST_NORM;
      ST_NORM: begin
        case (act)
          ACT_NAR, ACT_ZERO, ACT_UFLOW: state_d = ST_OUT;
          ACT_DONE:                     state_d = ST_ROUND;
          default:                      state_d = ST_NORM;
        endcase
      end
      ST_ROUND: state_d = ST_OUT;
      ST_OUT:   if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_OUT);
    out_flags = flags_q;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      nar_q    <= 1'b0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      e_q      <= '0;
      mant_q   <= '0;
      out_fp   <= '0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_done) begin
            sign_q   <= in_sign;
            zero_q   <= in_zero;
            nar_q    <= in_nar;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            e_q      <= {2'b00, in_exp};
            mant_q   <= in_mant;
          end
        end
        ST_NORM: begin
          case (act)
            ACT_NAR: begin
              out_fp  <= FP16_NAN[FP_W-1:0];
              flags_q <= '{nan: 1'b1, overflow: 1'b0, underflow: 1'b0};
            end
            ACT_ZERO: begin
              out_fp  <= '0;
              flags_q <= '0;
            end
            ACT_UFLOW: begin
              out_fp  <= {sign_q, {(FP_W-1){1'b0}}};
              flags_q <= '{nan: 1'b0, overflow: 1'b0, underflow: 1'b1};
            end
            ACT_RSHIFT: begin
              // The bit shifted out becomes the new guard; the old guard
              // is now further down and only matters as sticky.
              mant_q   <= mant_q >> 1;
              guard_q  <= mant_q[0];
              sticky_q <= sticky_q | guard_q;
              e_q      <= e_q + E_ONE;
            end
            ACT_LSHIFT: begin
              mant_q <= mant_q << 1;
              e_q    <= e_q - E_ONE;
            end
            default: ;
          endcase
        end
        ST_ROUND: begin
          out_fp  <= rnd_fp;
          flags_q <= '{nan: 1'b0, overflow: rnd_ovf, underflow: rnd_unf};
        end
        default: ;
      endcase
    end
  end

  // Clear has priority so a clear issued alongside a dropped pulse wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      overrun <= 1'b0;
    else if (clr_overrun)          overrun <= 1'b0;
    else if (in_done && !in_ready) overrun <= 1'b1;
  end

  fp16_rne_round #(
    .EXP_WIDTH (EXP_WIDTH),
    .MAN_WIDTH (MAN_WIDTH)
  ) u_round (
    .sign      (sign_q),
    .e         (e_q),
    .mant      (mant_q[MAN_WIDTH:0]),
    .guard     (guard_q),
    .sticky    (sticky_q),
    .fp        (rnd_fp),
    .overflow  (rnd_ovf),
    .underflow (rnd_unf)
  );

endmodule

// File: tb/tb_fp_posit_norm_pack.sv
module tb_fp_posit_norm_pack;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        in_done = 1'b0, in_sign = 1'b0, in_zero = 1'b0, in_nar = 1'b0;
  logic [4:0]  in_exp = '0;
  logic [13:0] in_mant = '0;
  logic        in_ready, out_valid, overrun;
  logic        out_ready = 1'b1, clr_overrun = 1'b0;
  logic [15:0] out_fp;
  logic [2:0]  out_flags;

  fp_posit_norm_pack dut (
    .clk         (clk),
    .rst         (rst),
    .in_done     (in_done),
    .in_sign     (in_sign),
    .in_exp      (in_exp),
    .in_mant     (in_mant),
    .in_zero     (in_zero),
    .in_nar      (in_nar),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_fp      (out_fp),
    .out_flags   (out_flags),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cyc = 0;
  logic prev_valid = 1'b0;
  logic [18:0] head;

  // ---------------- scoreboard ----------------
  logic [18:0] exp_q[$];   // {fp, flags}
  int          lat_q[$];   // expected cycles from in_done edge to out_valid; -1 = unchecked

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference: value = mant * 2^(exp-15-10). Locate the leading one, derive
  // the normalised exponent, round the discarded bits to nearest-even.
  function automatic logic [18:0] model(input logic s, input logic [4:0] ex,
                                        input logic [13:0] m, input logic z,
                                        input logic n, output int lat);
    int p, e, sh, kept, rem, half;
    logic [4:0] e5;
    logic [9:0] f10;
    lat = -1;
    if (n) return {16'h7E00, 3'b100};
    if (z || m == 14'd0) return {16'h0000, 3'b000};
    p = 13;
    while (p > 0 && !m[p]) p--;
    e = int'(ex) + p - 10;
    if (p > 10) begin
      sh   = p - 10;
      kept = int'(m) >> sh;
      rem  = int'(m) & ((1 << sh) - 1);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (kept % 2) == 1)) kept++;
    end else begin
      sh = 10 - p;
      if (e < 1) return {s, 15'd0, 3'b001};
      kept = int'(m) << sh;
    end
    lat = 2 + sh;
    if (kept == 2048) begin
      kept = 1024;
      e++;
    end
    if (e >= 31) return {s, 5'h1F, 10'h000, 3'b010};
    e5  = e[4:0];
    f10 = kept[9:0];
    return {s, e5, f10, 3'b000};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid) begin
        if (!prev_valid && lat_q.size() > 0 && lat_q[0] >= 0)
          check("latency", 32'(cyc - done_cyc), 32'(lat_q[0]));
        check("in_ready_busy", 32'(in_ready), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_valid: got out_fp=0x%0h, required no output", out_fp);
        end else begin
          head = exp_q[0];
          check("out_fp", 32'(out_fp), 32'(head[18:3]));
          check("out_flags", 32'(out_flags), 32'(head[2:0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
          end
        end
      end
      prev_valid = out_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end at 1 time unit after a rising edge.
  task automatic send(input logic s, input logic [4:0] ex, input logic [13:0] m,
                      input logic z, input logic n);
    logic [18:0] r;
    int l;
    r = model(s, ex, m, z, n, l);
    exp_q.push_back(r);
    lat_q.push_back(l);
    in_sign = s; in_exp = ex; in_mant = m; in_zero = z; in_nar = n;
    in_done = 1'b1;
    @(posedge clk); #1;
    done_cyc = cyc;
    in_done  = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("valid_seen", 32'(out_valid), 32'd1);
  endtask

  task automatic run(input logic s, input logic [4:0] ex, input logic [13:0] m,
                     input logic z, input logic n);
    send(s, ex, m, z, n);
    wait_idle();
  endtask

  task automatic pulse_done(input logic [4:0] ex, input logic [13:0] m);
    in_exp = ex; in_mant = m; in_done = 1'b1;
    @(posedge clk); #1;
    in_done = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [18:0] r;
    int l;

    // Pin the reference model to hand-computed values.
    r = model(0, 15, 14'h0400, 0, 0, l); check("model_one", 32'(r), {13'd0, 16'h3C00, 3'b000}); check("model_one_lat", 32'(l), 32'd2);
    r = model(0, 15, 14'h0C00, 0, 0, l); check("model_rsh", 32'(r), {13'd0, 16'h4200, 3'b000}); check("model_rsh_lat", 32'(l), 32'd3);
    r = model(0, 15, 14'h0801, 0, 0, l); check("model_tie_even", 32'(r), {13'd0, 16'h4000, 3'b000});
    r = model(0, 15, 14'h0803, 0, 0, l); check("model_tie_odd", 32'(r), {13'd0, 16'h4002, 3'b000});
    r = model(1, 30, 14'h2000, 0, 0, l); check("model_ovf", 32'(r), {13'd0, 16'hFC00, 3'b010});
    r = model(0, 2, 14'h0040, 0, 0, l);  check("model_unf", 32'(r), {13'd0, 16'h0000, 3'b001});
    r = model(0, 7, 14'h0123, 0, 1, l);  check("model_nar", 32'(r), {13'd0, 16'h7E00, 3'b100});
    r = model(1, 9, 14'h0400, 1, 0, l);  check("model_zero", 32'(r), {13'd0, 16'h0000, 3'b000});
    r = model(0, 20, 14'h3FFF, 0, 0, l); check("model_carry", 32'(r), {13'd0, 16'h6000, 3'b000});

    // Reset values while rst is held low.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_fp", 32'(out_fp), 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    run(0, 15, 14'h0400, 0, 0);   // 1.0
    run(0, 15, 14'h0C00, 0, 0);   // one right shift
    run(0, 15, 14'h0801, 0, 0);   // tie, stays even
    run(0, 15, 14'h0803, 0, 0);   // tie, rounds to even
    run(1, 30, 14'h2000, 0, 0);   // overflow after 3 right shifts
    run(0, 2,  14'h0040, 0, 0);   // underflow during left shifts
    run(0, 7,  14'h0123, 0, 1);   // NaR
    run(1, 9,  14'h0400, 1, 0);   // zero flag, sign dropped
    run(1, 9,  14'h0000, 0, 0);   // zero mantissa
    run(0, 10, 14'h2003, 0, 0);   // sticky below half, no round
    run(0, 20, 14'h3FFF, 0, 0);   // rounding carry renormalises
    run(0, 25, 14'h0001, 0, 0);   // maximum left shifts
    run(1, 15, 14'h05A3, 0, 0);   // negative, no shift
    run(0, 30, 14'h07FF, 0, 0);   // largest finite
    run(0, 30, 14'h0FFF, 0, 0);   // overflow via rounding carry
    run(0, 28, 14'h1FFF, 0, 0);   // carry lands exactly on e=31
    run(0, 2,  14'h0200, 0, 0);   // smallest normal
    run(1, 1,  14'h0200, 0, 0);   // one step short: underflow, sign kept
    run(0, 0,  14'h0400, 0, 0);   // exponent already zero
    check("overrun_idle", 32'(overrun), 32'd0);

    // Random vectors against the model.
    for (int i = 0; i < 24; i++) begin
      run(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 14'($urandom_range(0, 16383)),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
    end

    // Back-pressure: result held, dropped input flagged, clear behaviour.
    out_ready = 1'b0;
    send(0, 15, 14'h0400, 0, 0);
    wait_valid();
    repeat (2) @(posedge clk);
    #1;
    pulse_done(5'd3, 14'h3FFF);
    check("overrun_set", 32'(overrun), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("held_out_fp", 32'(out_fp), 32'h3C00);
    check("held_in_ready", 32'(in_ready), 32'd0);
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;
    check("overrun_clr", 32'(overrun), 32'd0);
    clr_overrun = 1'b1;
    pulse_done(5'd4, 14'h0400);
    clr_overrun = 1'b0;
    check("overrun_clr_wins", 32'(overrun), 32'd0);
    out_ready = 1'b1;
    wait_idle();
    repeat (6) @(posedge clk);
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Reset while a result is waiting in OUT.
    out_ready = 1'b0;
    send(1, 15, 14'h05A3, 0, 0);
    wait_valid();
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    #1;
    check("rst_out_drop_valid", 32'(out_valid), 32'd0);
    check("rst_out_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_fp_clear", 32'(out_fp), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset while normalising; overrun set beforehand must clear too.
    send(0, 25, 14'h0001, 0, 0);
    pulse_done(5'd1, 14'h0001);
    check("overrun_norm", 32'(overrun), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    @(posedge clk); #1;
    check("rst_norm_valid", 32'(out_valid), 32'd0);
    check("rst_norm_in_ready", 32'(in_ready), 32'd1);
    check("rst_norm_overrun", 32'(overrun), 32'd0);
    rst = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    run(0, 15, 14'h0C00, 0, 0);   // recovers after abort

    repeat (5) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
